// File: rtl/cp0_irq_stack.sv
// cp0_irq_stack: coprocessor-0 for the dynamic pipeline with maskable
// external interrupts, a Count/Compare timer and a save stack of
// {Status, EPC} pairs so nested exceptions return to the right place.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   mfc0, addr, rdata combinational register read (rdata is 0 unless mfc0)
//   mtc0, wdata       register write to addr
//   pc, exception,    take an exception for the instruction at pc with
//   cause             ExcCode cause (0 = interrupt)
//   eret              return from exception (pops the save stack)
//   irq               level-sensitive interrupt requests
//   status, epc       current Status / EPC
//   exc_addr          fetch redirect: EPC while eret, else the handler vector
//   int_req           an enabled, unmasked interrupt is pending
//   depth, stack_ovf  occupied stack entries; sticky overflow flag
module cp0_irq_stack #(
  parameter int          NUM_IRQ      = 6,
  parameter int          STACK_DEPTH  = 4,
  parameter logic [31:0] EXC_VECTOR   = 32'h00400004,
  parameter logic [31:0] STATUS_RESET = 32'h00000001
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mfc0,
  input  logic                           mtc0,
  input  logic [4:0]                     addr,
  input  logic [31:0]                    wdata,
  input  logic [31:0]                    pc,
  input  logic                           exception,
  input  logic [4:0]                     cause,
  input  logic                           eret,
  input  logic [NUM_IRQ-1:0]             irq,
  output logic [31:0]                    rdata,
  output logic [31:0]                    status,
  output logic [31:0]                    epc,
  output logic [31:0]                    exc_addr,
  output logic                           int_req,
  output logic [$clog2(STACK_DEPTH):0]   depth,
  output logic                           stack_ovf
);

  localparam int AW = $clog2(STACK_DEPTH);
  localparam int DW = AW + 1;

  logic [31:0]        r_status;
  logic [31:0]        r_epc;
  logic [31:0]        r_count;
  logic [31:0]        r_compare;
  logic [4:0]         r_excCode;
  logic               r_ti;
  logic [NUM_IRQ-1:0] r_irqQ;
  logic [DW-1:0]      r_depth;
  logic               r_ovf;
  logic [31:0]        r_stackStatus [STACK_DEPTH];
  logic [31:0]        r_stackEpc    [STACK_DEPTH];

  logic [NUM_IRQ-1:0] w_ip;
  logic [31:0]        w_cause;
  logic               w_doEret;
  logic               w_doMtc0;
  logic               w_full;
  logic               w_empty;
  logic [DW-1:0]      w_depthDec;
  logic [AW-1:0]      w_pushIdx;
  logic [AW-1:0]      w_popIdx;

  // Exception outranks eret, which outranks mtc0; the loser is dropped.
  assign w_doEret   = eret & ~exception;
  assign w_doMtc0   = mtc0 & ~exception & ~eret;
  assign w_full     = (r_depth == DW'(STACK_DEPTH));
  assign w_empty    = (r_depth == '0);
  assign w_depthDec = r_depth - DW'(1);
  assign w_pushIdx  = r_depth[AW-1:0];
  assign w_popIdx   = w_depthDec[AW-1:0];

  // The top interrupt line is shared with the timer.
  always_comb begin
    w_ip            = r_irqQ;
    w_ip[NUM_IRQ-1] = r_irqQ[NUM_IRQ-1] | r_ti;
  end

  always_comb begin
    w_cause                = '0;
    w_cause[6:2]           = r_excCode;
    w_cause[8 +: NUM_IRQ]  = w_ip;
    w_cause[30]            = r_ti;
  end

  always_comb begin
    rdata = '0;
    if (mfc0) begin
      case (addr)
        5'd9:    rdata = r_count;
        5'd11:   rdata = r_compare;
        5'd12:   rdata = r_status;
        5'd13:   rdata = w_cause;
        5'd14:   rdata = r_epc;
        default: rdata = '0;
      endcase
    end
  end

  assign int_req   = r_status[0] & ~r_status[1] & (|(w_ip & r_status[8 +: NUM_IRQ]));
  assign exc_addr  = eret ? r_epc : EXC_VECTOR;
  assign status    = r_status;
  assign epc       = r_epc;
  assign depth     = r_depth;
  assign stack_ovf = r_ovf;

  // Timer and interrupt sampling run every cycle regardless of other events.
  // A Compare write clears TI even on the edge that would have set it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_ti    <= 1'b0;
      r_irqQ  <= '0;
    end else begin
      r_irqQ <= irq;
      if (w_doMtc0 && addr == 5'd9) r_count <= wdata;
      else                          r_count <= r_count + 32'd1;
      if (w_doMtc0 && addr == 5'd11)          r_ti <= 1'b0;
      else if (r_count + 32'd1 == r_compare)  r_ti <= 1'b1;
    end
  end

  // Architectural state: exception entry, eret and mtc0 writes.
  // On overflow the new EPC/Status still take effect; only the save is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_status  <= STATUS_RESET;
      r_epc     <= '0;
      r_compare <= 32'hFFFFFFFF;
      r_excCode <= '0;
      r_depth   <= '0;
      r_ovf     <= 1'b0;
    end else if (exception) begin
      r_epc     <= pc;
      r_status  <= {r_status[31:2], 1'b1, 1'b0};
      r_excCode <= cause;
      if (w_full) r_ovf   <= 1'b1;
      else        r_depth <= r_depth + DW'(1);
    end else if (w_doEret) begin
      if (!w_empty) begin
        r_status <= r_stackStatus[w_popIdx];
        r_epc    <= r_stackEpc[w_popIdx];
        r_depth  <= w_depthDec;
      end else begin
        r_status[1] <= 1'b0;
      end
    end else if (w_doMtc0) begin
      case (addr)
        5'd11: r_compare <= wdata;
        5'd12: begin
          r_status <= {1'b0, wdata[30:0]};
          if (wdata[31]) r_ovf <= 1'b0;
        end
        5'd14: r_epc <= wdata;
        default: ;
      endcase
    end
  end

  // Save stack storage; written only on a non-overflowing exception.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        r_stackStatus[i] <= '0;
        r_stackEpc[i]    <= '0;
      end
    end else if (exception && !w_full) begin
      r_stackStatus[w_pushIdx] <= r_status;
      r_stackEpc[w_pushIdx]    <= r_epc;
    end
  end

endmodule

// File: tb/tb_cp0_irq_stack.sv
// tb_cp0_irq_stack: directed self-checking bench for cp0_irq_stack.
// Inputs are driven 1 time unit after each rising edge and outputs are
// compared at that same point, away from the active edge.
module tb_cp0_irq_stack;

  logic        clk;
  logic        rst;
  logic        mfc0;
  logic        mtc0;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic        exception;
  logic [4:0]  cause;
  logic        eret;
  logic [5:0]  irq;
  logic [31:0] rdata;
  logic [31:0] status;
  logic [31:0] epc;
  logic [31:0] exc_addr;
  logic        int_req;
  logic [2:0]  depth;
  logic        stack_ovf;

  int checks;
  int errors;

  cp0_irq_stack #(
    .NUM_IRQ(6), .STACK_DEPTH(4),
    .EXC_VECTOR(32'h00400004), .STATUS_RESET(32'h00000001)
  ) dut (
    .clk(clk), .rst(rst), .mfc0(mfc0), .mtc0(mtc0), .addr(addr),
    .wdata(wdata), .pc(pc), .exception(exception), .cause(cause),
    .eret(eret), .irq(irq), .rdata(rdata), .status(status), .epc(epc),
    .exc_addr(exc_addr), .int_req(int_req), .depth(depth),
    .stack_ovf(stack_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mtc0 = 1'b0; exception = 1'b0; eret = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mfc0 = 1'b1; irq = '0; wdata = '0; pc = '0; cause = '0; addr = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    addr = 5'd12; #1;
    checks++; if (rdata !== 32'h00000001) begin errors++; $display("[TB] FAIL reset_status: got %h expected %h", rdata, 32'h00000001); end
    addr = 5'd13; #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_cause: got %h expected %h", rdata, 32'h0); end
    addr = 5'd14; #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_epc: got %h expected %h", rdata, 32'h0); end
    addr = 5'd11; #1;
    checks++; if (rdata !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL reset_compare: got %h expected %h", rdata, 32'hFFFFFFFF); end
    checks++; if (int_req !== 1'b0 || depth !== 3'd0 || stack_ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got int_req=%b depth=%0d ovf=%b expected 0/0/0", int_req, depth, stack_ovf); end
    mfc0 = 1'b0; #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL read_gate: got %h expected %h", rdata, 32'h0); end
    rst = 1'b0;
  endtask

  task automatic test_irq_exception();
    mtc0 = 1'b1; addr = 5'd12; wdata = 32'h00000101;
    tick();
    idle(); irq = 6'b000001; #1;
    checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL irq_latency: got %b expected %b", int_req, 1'b0); end
    tick();
    checks++; if (int_req !== 1'b1) begin errors++; $display("[TB] FAIL irq_req: got %b expected %b", int_req, 1'b1); end
    exception = 1'b1; cause = 5'd0; pc = 32'h00400100; #1;
    checks++; if (exc_addr !== 32'h00400004) begin errors++; $display("[TB] FAIL exc_vector: got %h expected %h", exc_addr, 32'h00400004); end
    tick();
    idle(); irq = '0;
    checks++; if (epc !== 32'h00400100 || status !== 32'h00000102) begin errors++; $display("[TB] FAIL exc_entry: got epc=%h status=%h expected 00400100/00000102", epc, status); end
    checks++; if (int_req !== 1'b0 || depth !== 3'd1) begin errors++; $display("[TB] FAIL exc_flags: got int_req=%b depth=%0d expected 0/1", int_req, depth); end
    mfc0 = 1'b1; addr = 5'd13; #1;
    checks++; if (rdata !== 32'h00000100) begin errors++; $display("[TB] FAIL cause_ip: got %h expected %h", rdata, 32'h00000100); end
    mfc0 = 1'b0;
  endtask

  task automatic test_nested();
    exception = 1'b1; cause = 5'd8; pc = 32'h00400200;
    tick();
    idle();
    checks++; if (depth !== 3'd2 || epc !== 32'h00400200) begin errors++; $display("[TB] FAIL nest_push: got depth=%0d epc=%h expected 2/00400200", depth, epc); end
    mfc0 = 1'b1; addr = 5'd13; #1;
    checks++; if (rdata !== 32'h00000020) begin errors++; $display("[TB] FAIL nest_cause: got %h expected %h", rdata, 32'h00000020); end
    mfc0 = 1'b0;
    eret = 1'b1; #1;
    checks++; if (exc_addr !== 32'h00400200) begin errors++; $display("[TB] FAIL eret1_addr: got %h expected %h", exc_addr, 32'h00400200); end
    tick();
    checks++; if (status !== 32'h00000102 || epc !== 32'h00400100 || depth !== 3'd1) begin errors++; $display("[TB] FAIL eret1_pop: got status=%h epc=%h depth=%0d expected 00000102/00400100/1", status, epc, depth); end
    checks++; if (exc_addr !== 32'h00400100) begin errors++; $display("[TB] FAIL eret2_addr: got %h expected %h", exc_addr, 32'h00400100); end
    tick();
    idle();
    checks++; if (status !== 32'h00000101 || epc !== 32'h0 || depth !== 3'd0) begin errors++; $display("[TB] FAIL eret2_pop: got status=%h epc=%h depth=%0d expected 00000101/00000000/0", status, epc, depth); end
  endtask

  task automatic test_timer();
    mtc0 = 1'b1; addr = 5'd9; wdata = 32'd0;
    tick();
    addr = 5'd11; wdata = 32'd10;
    tick();
    addr = 5'd12; wdata = 32'h00002001;
    tick();
    idle();
    repeat (7) tick();
    mfc0 = 1'b1; addr = 5'd9; #1;
    checks++; if (rdata !== 32'd9) begin errors++; $display("[TB] FAIL timer_count9: got %0d expected %0d", rdata, 9); end
    addr = 5'd13; #1;
    checks++; if (rdata !== 32'h00000020 || int_req !== 1'b0) begin errors++; $display("[TB] FAIL timer_early: got cause=%h int_req=%b expected 00000020/0", rdata, int_req); end
    tick();
    checks++; if (rdata !== 32'h40002020 || int_req !== 1'b1) begin errors++; $display("[TB] FAIL timer_fire: got cause=%h int_req=%b expected 40002020/1", rdata, int_req); end
    addr = 5'd9; #1;
    checks++; if (rdata !== 32'd10) begin errors++; $display("[TB] FAIL timer_count10: got %0d expected %0d", rdata, 10); end
    mtc0 = 1'b1; addr = 5'd11; wdata = 32'd100;
    tick();
    idle(); addr = 5'd13; #1;
    checks++; if (rdata !== 32'h00000020 || int_req !== 1'b0) begin errors++; $display("[TB] FAIL timer_clear: got cause=%h int_req=%b expected 00000020/0", rdata, int_req); end
    mfc0 = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] expAddr   [5];
    logic [31:0] expStatus [5];
    logic [2:0]  expDepth  [5];
    expAddr   = '{32'h1004, 32'h1002, 32'h1001, 32'h1000, 32'h0};
    expStatus = '{32'h2, 32'h2, 32'h2, 32'h3, 32'h1};
    expDepth  = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    mtc0 = 1'b1; addr = 5'd12; wdata = 32'h00000003;
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      exception = 1'b1; cause = 5'd4; pc = 32'h1000 + i;
      tick();
      if (i == 3) begin
        checks++; if (depth !== 3'd4 || stack_ovf !== 1'b0) begin errors++; $display("[TB] FAIL ovf_full: got depth=%0d ovf=%b expected 4/0", depth, stack_ovf); end
      end
    end
    idle();
    checks++; if (depth !== 3'd4 || stack_ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set: got depth=%0d ovf=%b expected 4/1", depth, stack_ovf); end
    checks++; if (epc !== 32'h1004 || status !== 32'h2) begin errors++; $display("[TB] FAIL ovf_entry: got epc=%h status=%h expected 00001004/00000002", epc, status); end
    for (int i = 0; i < 5; i++) begin
      eret = 1'b1; #1;
      checks++; if (exc_addr !== expAddr[i]) begin errors++; $display("[TB] FAIL ovf_eret%0d_addr: got %h expected %h", i, exc_addr, expAddr[i]); end
      tick();
      checks++; if (status !== expStatus[i] || depth !== expDepth[i]) begin errors++; $display("[TB] FAIL ovf_eret%0d: got status=%h depth=%0d expected %h/%0d", i, status, depth, expStatus[i], expDepth[i]); end
    end
    idle();
    checks++; if (epc !== 32'h0 || stack_ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got epc=%h ovf=%b expected 00000000/1", epc, stack_ovf); end
    mtc0 = 1'b1; addr = 5'd12; wdata = 32'h80000001;
    tick();
    idle();
    checks++; if (stack_ovf !== 1'b0 || status !== 32'h00000001) begin errors++; $display("[TB] FAIL ovf_clear: got ovf=%b status=%h expected 0/00000001", stack_ovf, status); end
  endtask

  task automatic test_back_to_back();
    exception = 1'b1; cause = 5'd3; pc = 32'h2000;
    mtc0 = 1'b1; addr = 5'd14; wdata = 32'hDEAD;
    tick();
    checks++; if (epc !== 32'h2000 || depth !== 3'd1) begin errors++; $display("[TB] FAIL exc_mtc0: got epc=%h depth=%0d expected 00002000/1", epc, depth); end
    exception = 1'b0; eret = 1'b1; wdata = 32'hBEEF; #1;
    checks++; if (exc_addr !== 32'h2000) begin errors++; $display("[TB] FAIL eret_mtc0_addr: got %h expected %h", exc_addr, 32'h2000); end
    tick();
    idle();
    checks++; if (epc !== 32'h0 || status !== 32'h1 || depth !== 3'd0) begin errors++; $display("[TB] FAIL eret_mtc0: got epc=%h status=%h depth=%0d expected 00000000/00000001/0", epc, status, depth); end
    mtc0 = 1'b1; addr = 5'd11; wdata = 32'h55;
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      exception = 1'b1; cause = 5'd8; pc = 32'h3000 + i;
      tick();
    end
    idle();
    checks++; if (depth !== 3'd4 || stack_ovf !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset: got depth=%0d ovf=%b expected 4/1", depth, stack_ovf); end
    #2 rst = 1'b1;
    #1;
    checks++; if (status !== 32'h1 || epc !== 32'h0 || depth !== 3'd0 || stack_ovf !== 1'b0) begin errors++; $display("[TB] FAIL async_reset: got status=%h epc=%h depth=%0d ovf=%b expected 00000001/00000000/0/0", status, epc, depth, stack_ovf); end
    mfc0 = 1'b1; addr = 5'd11; #0.5;
    checks++; if (rdata !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL async_compare: got %h expected %h", rdata, 32'hFFFFFFFF); end
    addr = 5'd9; #0.2;
    checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL async_count: got %h expected %h", rdata, 32'h0); end
    mfc0 = 1'b0; rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_irq_exception();
    test_nested();
    test_timer();
    test_overflow();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_irq_stack.md
Name: cp0_irq_stack

Overview:
- Parametrised coprocessor-0 for the dynamic pipeline.
- Adds over the current CP0:
  - NUM_IRQ maskable external interrupt lines.
  - A Count/Compare timer interrupt.
  - A STACK_DEPTH-deep Status/EPC save stack, so that nested exceptions (e.g. a syscall inside a handler) return correctly.
- Sits beside the ID/EX stage: the pipeline reads and writes registers with mfc0/mtc0, signals exception/eret, and redirects fetch to exc_addr.

Parameters:
- NUM_IRQ, 6, external interrupt lines (1..8); line NUM_IRQ-1 is shared with the timer.
- STACK_DEPTH, 4, number of saved {Status, EPC} pairs (power of two, >=2).
- EXC_VECTOR, 32'h00400004, handler entry address.
- STATUS_RESET, 32'h00000001, Status value at reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- mfc0  in  1  read-enable qualifier for rdata.
- mtc0  in  1  write wdata to register addr.
- addr  in  5  CP0 register number.
- wdata  in  32  mtc0 data.
- pc  in  32  PC of the excepting instruction.
- exception  in  1  take exception this cycle.
- cause  in  5  ExcCode; 0 = interrupt.
- eret  in  1  return from exception.
- irq  in  NUM_IRQ  level-sensitive interrupt requests.
- rdata  out  32  register read data.
- status  out  32  current Status.
- epc  out  32  current EPC.
- exc_addr  out  32  eret ? EPC : EXC_VECTOR.
- int_req  out  1  interrupt should be taken.
- depth  out  $clog2(STACK_DEPTH)+1  occupied stack entries.
- stack_ovf  out  1  sticky overflow flag.

Behaviour:

Register map (all other addresses read 0; writes to them are ignored):
- 9 = Count.
- 11 = Compare.
- 12 = Status:
  - bit0 IE.
  - bit1 EXL.
  - bits[8+NUM_IRQ-1:8] IM.
  - All other bits are stored as written.
- 13 = Cause:
  - bits[6:2] ExcCode.
  - bits[8+NUM_IRQ-1:8] IP.
  - bit30 TI.
  - Cause is read-only to mtc0, except that the write is ignored entirely.
- 14 = EPC.

Reset (asynchronous) values:
- Status = STATUS_RESET.
- Cause = 0, EPC = 0, Count = 0.
- Compare = 32'hFFFFFFFF.
- Stack cleared, depth = 0, stack_ovf = 0.

Read path:
- rdata = mfc0 ? reg[addr] : 0. Combinational, no latency.
- A read of Cause returns live IP and TI.

IRQ sampling:
- irq is registered once: IP[i] = irq[i] delayed by 1 cycle.
- IP[NUM_IRQ-1] = irq_q[NUM_IRQ-1] | TI.

Timer:
- Count increments every cycle and wraps 32'hFFFFFFFF -> 0.
- On the edge where Count+1 == Compare, TI is set, so TI is visible while Count == Compare.
- An mtc0 to Compare clears TI.
- An mtc0 to Count loads wdata with no increment that cycle.
- TI set and an mtc0 Compare write in the same cycle: the clear wins.

Interrupt request:
- int_req = IE & ~EXL & |(IP & IM). Combinational.

Per-edge priority:
- exception > eret > mtc0.
- A lower-priority event in the same cycle is dropped.
- Count/TI/IP updates always proceed.

Exception:
- If depth < STACK_DEPTH: push {Status, EPC} and increment depth.
- Otherwise (depth == STACK_DEPTH): no push, depth unchanged, stack_ovf set.
- Then EPC = pc, Status.EXL = 1, Status.IE = 0, Cause.ExcCode = cause.

eret:
- If depth > 0: pop; Status and EPC are restored from the top entry; depth decrements.
- If depth == 0: clear Status.EXL only; EPC unchanged.
- exc_addr reflects the pre-edge EPC in the eret cycle.

stack_ovf:
- Cleared only by reset, or by an mtc0 to Status with wdata bit31 = 1 (that bit itself is not stored).

Reset mid-handler:
- All state returns to reset values immediately; pending stack contents are lost.

Test Plan:
1. Reset, then mfc0 addr 12/13/14/11 -> rdata 32'h00000001 / 0 / 0 / 32'hFFFFFFFF; int_req=0; depth=0.
2. mtc0 Status=32'h00000101, then irq[0]=1 -> int_req=1 one cycle after irq rises. Then exception cause=0, pc=32'h00400100 -> EPC=32'h00400100, Status=32'h00000102, int_req=0, depth=1.
3. Nested case: after scenario 2, exception cause=8, pc=32'h00400200 -> depth=2. First eret -> exc_addr=32'h00400200; restores Status=32'h00000102 and EPC=32'h00400100. Second eret -> exc_addr=32'h00400100; Status=32'h00000101, depth=0.
4. Timer: mtc0 Count=0, Compare=10, Status IM[NUM_IRQ-1]|IE -> TI and int_req assert while Count==10. mtc0 Compare=100 -> TI=0 the next cycle.
5. Overflow: STACK_DEPTH+1 back-to-back exceptions -> depth saturates at 4, stack_ovf=1. Then 5 erets -> depth 0, final eret clears EXL only. mtc0 Status with bit31=1 clears stack_ovf.
6. Same-cycle exception+mtc0 to EPC, and eret+mtc0 -> the mtc0 is ignored in both cases. Asynchronous rst asserted mid-handler -> all outputs return to reset values before the next clk edge.
